ftm_data_responder: RTL and testbench

- Responder (memory side) of the core data-memory req/gnt/rvalid interface. Serves the FTM scratch store that the recovery routine uses to save and restore register-file state.
- Sits behind the recovery-mode data mux. Receives core requests and answers them with grant, then in-order response, at a configurable grant wait.
- Also counts accepted writes so the recovery controller can confirm a complete checkpoint.

---
 rtl/ftm_data_responder.sv | 137 +++++++++++++
 tb/tb_ftm_data_responder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ftm_data_responder.sv
// FTM scratch-store responder on the core data req/gnt/rvalid port.
// Grants after GntDelay wait cycles, answers one cycle later, counts writes.
module ftm_data_responder #(
  parameter logic [31:0] BaseAddr = 32'h0000_0000,
  parameter int unsigned NumWords = 64,
  parameter int unsigned GntDelay = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  input  logic        wr_clear_i,
  output logic [15:0] wr_count_o
);

  localparam int unsigned AW = $clog2(NumWords);
  localparam logic [3:0] GntDly = 4'(GntDelay);
  localparam logic [31:0] SpanBytes = 32'(NumWords * 4);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [31:0]   mem [NumWords];

  logic          accept;
  logic [31:0]   offset;
  logic          addr_err;
  logic [AW-1:0] idx;
  logic          wr_ok;

  logic          rvalid_q;
  logic          err_q;
  logic [31:0]   rdata_q;
  logic [15:0]   wr_count_q;

  assign data_gnt_o = data_req_i && (cnt_q == GntDly);
  assign accept     = data_req_i && data_gnt_o;

  // Out-of-window addresses are errors; the index is never wrapped.
  assign offset   = data_addr_i - BaseAddr;
  assign addr_err = (data_addr_i < BaseAddr)
                 || (offset >= SpanBytes)
                 || (data_addr_i[1:0] != 2'b00);
  assign idx      = offset[AW+1:2];
  assign wr_ok    = accept && data_we_i && !addr_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (data_req_i && !data_gnt_o) begin
            cnt_q   <= 4'd1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!data_req_i || data_gnt_o) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Storage survives reset; only accesses in a reset cycle are blocked.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_ok) begin
      for (int k = 0; k < 4; k++) begin
        if (data_be_i[k]) begin
          mem[idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= accept;
      err_q    <= accept && addr_err;
      if (accept) begin
        if (addr_err || data_we_i) begin
          rdata_q <= '0;
        end else begin
          rdata_q <= mem[idx];
        end
      end
    end
  end

  // A response still in flight when reset arrives is never shown.
  assign data_rvalid_o = rvalid_q && !rst_i;
  assign data_err_o    = err_q && !rst_i;
  assign data_rdata_o  = rdata_q;

  // Clear takes effect before the increment of a coincident write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_count_q <= '0;
    end else if (wr_ok) begin
      if (wr_clear_i) begin
        wr_count_q <= 16'd1;
      end else if (wr_count_q != 16'hFFFF) begin
        wr_count_q <= wr_count_q + 16'd1;
      end
    end else if (wr_clear_i) begin
      wr_count_q <= '0;
    end
  end

  assign wr_count_o = wr_count_q;

endmodule

// File: tb/tb_ftm_data_responder.sv
// Bench for ftm_data_responder: two instances (no wait / 3 waits)
// checked every cycle against a word-array model plus literal pins.
module tb_ftm_data_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [2];
  logic        we    [2];
  logic [3:0]  be    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        clr   [2];
  logic        gnt   [2];
  logic        rvalid[2];
  logic        err   [2];
  logic [31:0] rdata [2];
  logic [15:0] wrc   [2];

  int total = 0;
  int passed = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  ftm_data_responder #(
    .BaseAddr(32'h0000_0000), .NumWords(64), .GntDelay(0)
  ) dut0 (
    .clk_i(clk), .rst_i(rst),
    .data_req_i(req[0]), .data_gnt_o(gnt[0]),
    .data_rvalid_o(rvalid[0]), .data_we_i(we[0]),
    .data_be_i(be[0]), .data_addr_i(addr[0]),
    .data_wdata_i(wdata[0]), .data_rdata_o(rdata[0]),
    .data_err_o(err[0]), .wr_clear_i(clr[0]),
    .wr_count_o(wrc[0])
  );

  ftm_data_responder #(
    .BaseAddr(32'h0000_1000), .NumWords(64), .GntDelay(3)
  ) dut1 (
    .clk_i(clk), .rst_i(rst),
    .data_req_i(req[1]), .data_gnt_o(gnt[1]),
    .data_rvalid_o(rvalid[1]), .data_we_i(we[1]),
    .data_be_i(be[1]), .data_addr_i(addr[1]),
    .data_wdata_i(wdata[1]), .data_rdata_o(rdata[1]),
    .data_err_o(err[1]), .wr_clear_i(clr[1]),
    .wr_count_o(wrc[1])
  );

  function automatic int dly(int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] base(int d);
    return (d == 0) ? 32'h0 : 32'h1000;
  endfunction

  function automatic bit bad_addr(int d, logic [31:0] a);
    if (a < base(d)) return 1'b1;
    if ((a - base(d)) >= 32'd256) return 1'b1;
    if (a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s dut%0d: got %h want %h at %0t", name, d, act, exp, $time);
  endtask

  task automatic fail_now(string name, int d);
    total++;
    $display("FAIL %s dut%0d: timed out at %0t", name, d, $time);
  endtask

  // Model: word arrays, one-deep response slot, saturating counter.
  logic [31:0] mm [2][64];
  int          held[2] = '{0, 0};
  bit          pv  [2] = '{0, 0};
  bit          perr[2] = '{0, 0};
  logic [31:0] prd [2];
  int          mwc [2] = '{0, 0};

  initial begin
    bit ge, acc;
    int ix;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        ge = req[d] && (held[d] == dly(d));
        if (chk_on) begin
          chk("m_gnt", d, 32'(gnt[d]), 32'(ge));
          chk("m_rvalid", d, 32'(rvalid[d]), 32'(pv[d] && !rst));
          chk("m_err", d, 32'(err[d]), 32'(pv[d] && perr[d] && !rst));
          chk("m_rdata", d, rdata[d], prd[d]);
          chk("m_wrc", d, 32'(wrc[d]), 32'(mwc[d]));
        end
        if (rst) begin
          held[d] = 0; pv[d] = 0; perr[d] = 0;
          prd[d] = '0; mwc[d] = 0;
        end else begin
          acc = req[d] && ge;
          pv[d] = acc;
          perr[d] = 0;
          if (acc) begin
            held[d] = 0;
            ix = int'((addr[d] - base(d)) >> 2);
            if (bad_addr(d, addr[d])) begin
              perr[d] = 1; prd[d] = '0;
              if (clr[d]) mwc[d] = 0;
            end else if (we[d]) begin
              for (int k = 0; k < 4; k++)
                if (be[d][k]) mm[d][ix][8*k +: 8] = wdata[d][8*k +: 8];
              prd[d] = '0;
              if (clr[d]) mwc[d] = 1;
              else if (mwc[d] < 65535) mwc[d]++;
            end else begin
              prd[d] = mm[d][ix];
              if (clr[d]) mwc[d] = 0;
            end
          end else begin
            held[d] = req[d] ? held[d] + 1 : 0;
            if (clr[d]) mwc[d] = 0;
          end
        end
      end
    end
  end

  task automatic op(input int d, input bit w, input logic [3:0] b,
                    input logic [31:0] a, input logic [31:0] wd,
                    output logic [31:0] rd, output logic e, output int waits);
    @(posedge clk); #1;
    req[d] = 1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
    waits = 0;
    forever begin
      @(negedge clk);
      if (gnt[d] === 1'b1) break;
      waits++;
      if (waits > 40) begin
        fail_now("gnt_wait", d);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req[d] = 0;
    @(negedge clk);
    chk("op_rvalid", d, 32'(rvalid[d]), 32'd1);
    rd = rdata[d];
    e = err[d];
  endtask

  function automatic logic [31:0] raddr(int d);
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return $urandom;
    if (r == 1) return base(d) + 32'($urandom_range(0, 300));
    return base(d) + 32'($urandom_range(0, 69) * 4);
  endfunction

  initial begin
    logic [31:0] rd;
    logic e;
    int w;
    bit accp[2];
    rst = 1;
    for (int d = 0; d < 2; d++) begin
      req[d] = 0; we[d] = 0; be[d] = 0; addr[d] = 0;
      wdata[d] = 0; clr[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk_on = 1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_rvalid", d, 32'(rvalid[d]), 32'd0);
      chk("rst_rdata", d, rdata[d], 32'd0);
      chk("rst_wrc", d, 32'(wrc[d]), 32'd0);
    end

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++)
        op(d, 1, 4'hF, base(d) + 32'(i * 4), $urandom, rd, e, w);

    @(posedge clk); #1 clr[0] = 1;
    @(posedge clk); #1 clr[0] = 0;

    op(0, 1, 4'hF, 32'h10, 32'hDEADBEEF, rd, e, w);
    chk("wr_nowait", 0, 32'(w), 32'd0);
    op(0, 0, 4'hF, 32'h10, 32'h0, rd, e, w);
    chk("rd_nowait", 0, 32'(w), 32'd0);
    chk("rd_data", 0, rd, 32'hDEADBEEF);
    chk("rd_cnt1", 0, 32'(wrc[0]), 32'd1);

    op(0, 1, 4'hF, 32'h4, 32'h11223344, rd, e, w);
    op(0, 1, 4'b0101, 32'h4, 32'hAABBCCDD, rd, e, w);
    op(0, 0, 4'hF, 32'h4, 32'h0, rd, e, w);
    chk("be_data", 0, rd, 32'h11BB33DD);
    chk("be_err", 0, 32'(e), 32'd0);

    op(0, 1, 4'hF, 32'h100, 32'h12345678, rd, e, w);
    chk("oor_err", 0, 32'(e), 32'd1);
    chk("oor_rdata", 0, rd, 32'd0);
    chk("oor_cnt", 0, 32'(wrc[0]), 32'd3);
    op(0, 0, 4'hF, 32'h102, 32'h0, rd, e, w);
    chk("mis_err", 0, 32'(e), 32'd1);
    op(0, 0, 4'hF, 32'hFC, 32'h0, rd, e, w);
    chk("top_err", 0, 32'(e), 32'd0);

    @(posedge clk); #1;
    req[1] = 1; we[1] = 0; be[1] = 4'hF; addr[1] = 32'h1004;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("d3_gnt", 1, 32'(gnt[1]), 32'(c == 3));
    end
    @(posedge clk); #1 req[1] = 0;
    @(negedge clk);
    chk("d3_rvalid", 1, 32'(rvalid[1]), 32'd1);

    @(posedge clk); #1 req[1] = 1;
    @(negedge clk); chk("drop_gnt0", 1, 32'(gnt[1]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("drop_gnt1", 1, 32'(gnt[1]), 32'd0);
    @(posedge clk); #1 req[1] = 0;
    @(negedge clk); chk("drop_gnt2", 1, 32'(gnt[1]), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("drop_rvalid", 1, 32'(rvalid[1]), 32'd0);
    end
    op(1, 0, 4'hF, 32'h1008, 32'h0, rd, e, w);
    chk("drop_idle", 1, 32'(w), 32'd3);

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i < 8) begin
        req[0] = 1; we[0] = 0; addr[0] = 32'(i * 4);
      end else req[0] = 0;
      @(negedge clk);
      if (i < 8) chk("st_gnt", 0, 32'(gnt[0]), 32'd1);
      if (i >= 1 && i < 9) begin
        chk("st_rvalid", 0, 32'(rvalid[0]), 32'd1);
        chk("st_rdata", 0, rdata[0], mm[0][i-1]);
      end
    end

    @(posedge clk); #1;
    req[0] = 1; we[0] = 0; addr[0] = 32'h10;
    @(negedge clk); chk("rr_gnt", 0, 32'(gnt[0]), 32'd1);
    @(posedge clk); #1 req[0] = 0; rst = 1;
    @(negedge clk); chk("rr_rvalid0", 0, 32'(rvalid[0]), 32'd0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk); chk("rr_rvalid1", 0, 32'(rvalid[0]), 32'd0);
    op(0, 0, 4'hF, 32'h10, 32'h0, rd, e, w);
    chk("rr_keep", 0, rd, 32'hDEADBEEF);

    op(0, 1, 4'hF, 32'h20, 32'h1, rd, e, w);
    op(0, 1, 4'hF, 32'h24, 32'h2, rd, e, w);
    @(posedge clk); #1;
    req[0] = 1; we[0] = 1; addr[0] = 32'h28; clr[0] = 1;
    @(negedge clk);
    @(posedge clk); #1 req[0] = 0; clr[0] = 0;
    @(negedge clk); chk("clr_wr", 0, 32'(wrc[0]), 32'd1);

    accp = '{0, 0};
    repeat (3000) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) accp[d] = req[d] && gnt[d];
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        clr[d] = ($urandom_range(0, 29) == 0);
        if (req[d] && !accp[d]) begin
          if (d == 1 && $urandom_range(0, 15) == 0) req[d] = 0;
        end else begin
          req[d] = ($urandom_range(0, 9) < 7);
          we[d] = 1'($urandom);
          be[d] = 4'($urandom);
          addr[d] = raddr(d);
          wdata[d] = $urandom;
        end
      end
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin req[d] = 0; clr[d] = 0; end
    repeat (6) @(posedge clk);
    #1 clr[0] = 1;
    @(posedge clk); #1 clr[0] = 0;
    for (int i = 0; i < 65535; i++) begin
      req[0] = 1; we[0] = 1; be[0] = 4'($urandom);
      addr[0] = 32'($urandom_range(0, 63) * 4);
      wdata[0] = $urandom;
      @(posedge clk); #1;
    end
    req[0] = 0;
    @(negedge clk); chk("sat_full", 0, 32'(wrc[0]), 32'hFFFF);
    op(0, 1, 4'hF, 32'h30, 32'h5, rd, e, w);
    chk("sat_hold", 0, 32'(wrc[0]), 32'hFFFF);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
